// File: rtl/qk_seq_pkg.sv
// Shared encodings for the QK instruction sequencer: inst word bit positions,
// field widths and the controller state type.
package qk_seq_pkg;

    localparam int unsigned INST_W         = 19;
    localparam int unsigned INST_SFP_DIV   = 18;
    localparam int unsigned INST_SFP_ACC   = 17;
    localparam int unsigned INST_OFIFO_RD  = 16;
    localparam int unsigned INST_QKMEM_ADD = 12;  // lsb of the 4-bit qkmem address field
    localparam int unsigned INST_PMEM_ADD  = 8;   // lsb of the 4-bit pmem address field
    localparam int unsigned INST_EXECUTE   = 7;
    localparam int unsigned INST_LOAD      = 6;
    localparam int unsigned INST_QMEM_RD   = 5;
    localparam int unsigned INST_QMEM_WR   = 4;
    localparam int unsigned INST_KMEM_RD   = 3;
    localparam int unsigned INST_KMEM_WR   = 2;
    localparam int unsigned INST_PMEM_RD   = 1;
    localparam int unsigned INST_PMEM_WR   = 0;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_Q,
        S_WR_K,
        S_LOAD,
        S_GAP,
        S_EXEC,
        S_DRAIN,
        S_MOVE,
        S_SFP_RD,
        S_SFP_ACC,
        S_SFP_DIV,
        S_SFP_WB,
        S_DONE
    } seq_state_e;

endpackage

// File: rtl/qk_inst_sequencer_phase_counter.sv
// Loadable down-counter shared by every timed phase; tc_o flags the last
// cycle of the phase (count of zero).
module seq_phase_counter
    import qk_seq_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == '0);

endmodule

// File: rtl/qk_inst_sequencer.sv
// Autonomous Q/K write, load, execute, move and sfp-normalize sequencer for fullchip.
// Optional QK_SEQ_PERF_EN adds a saturating busy-cycle counter on perf_cycles.
module qk_inst_sequencer
    import qk_seq_pkg::*;
#(
    parameter int unsigned bw      = 8,
    parameter int unsigned pr      = 8,
    parameter int unsigned col     = 8,
    parameter int unsigned rows    = 8,
    parameter int unsigned GAP     = 10,
    parameter int unsigned DRAIN   = 10,
    parameter int unsigned DIV_LAT = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [pr*bw-1:0]   in_data,
    output logic [pr*bw-1:0]   mem_in,
    output logic [INST_W-1:0]  inst,
    output logic               busy,
    output logic               done
`ifdef QK_SEQ_PERF_EN
   ,output logic [15:0]        perf_cycles
`endif
);

    if (rows == 0 || rows > 16 || col == 0 || col > 16) begin : g_bad_size
        $error("qk_inst_sequencer: rows and col must be within 1..16");
    end
    if (GAP == 0 || GAP > 256 || DRAIN == 0 || DRAIN > 256 || DIV_LAT == 0 || DIV_LAT > 256) begin : g_bad_lat
        $error("qk_inst_sequencer: GAP, DRAIN and DIV_LAT must be within 1..256");
    end

    localparam logic [ADDR_W-1:0] ROW_LAST  = ADDR_W'(rows - 1);
    localparam logic [CNT_W-1:0]  COL_N     = CNT_W'(col);
    localparam logic [CNT_W-1:0]  LOAD_LAST = CNT_W'(col + 2);

    seq_state_e          state_q, state_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic [pr*bw-1:0]    mem_in_q, mem_in_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                cnt_load, cnt_dec, tc;
    logic [CNT_W-1:0]    cnt_val, cnt, k_n, wr_last;
    logic [ADDR_W-1:0]   qk_add, pm_add;

    assign qk_add  = inst_q[INST_QKMEM_ADD +: ADDR_W];
    assign pm_add  = inst_q[INST_PMEM_ADD +: ADDR_W];
    assign wr_last = (state_q == S_WR_Q) ? CNT_W'(rows - 1) : CNT_W'(col - 1);

    seq_phase_counter #(.W(CNT_W)) u_phase_cnt (
        .clk_i      (clk),
        .rst_n_i    (reset_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt),
        .tc_o       (tc)
    );

    // Outputs are computed for the cycle that follows, so each registered
    // inst word lines up with the state it belongs to.
    always_comb begin
        state_d    = state_q;
        inst_d     = '0;
        mem_in_d   = mem_in_q;
        in_ready_d = 1'b0;
        done_d     = 1'b0;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        cnt_dec    = 1'b0;
        k_n        = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_WR_Q;
                    in_ready_d = 1'b1;
                    cnt_load   = 1'b1;
                    cnt_val    = CNT_W'(rows - 1);
                end
            end
            // The last accept drops in_ready; the following cycle shows its
            // write and then hands over to the next phase.
            S_WR_Q, S_WR_K: begin
                if (in_ready_q) begin
                    in_ready_d = 1'b1;
                    if (in_valid) begin
                        mem_in_d = in_data;
                        if (state_q == S_WR_Q) begin
                            inst_d[INST_QMEM_WR] = 1'b1;
                        end else begin
                            inst_d[INST_KMEM_WR] = 1'b1;
                        end
                        inst_d[INST_QKMEM_ADD +: ADDR_W] = ADDR_W'(wr_last - cnt);
                        if (tc) begin
                            in_ready_d = 1'b0;
                        end else begin
                            cnt_dec = 1'b1;
                        end
                    end
                end else if (state_q == S_WR_Q) begin
                    state_d    = S_WR_K;
                    in_ready_d = 1'b1;
                    cnt_load   = 1'b1;
                    cnt_val    = CNT_W'(col - 1);
                end else begin
                    state_d           = S_LOAD;
                    cnt_load          = 1'b1;
                    cnt_val           = LOAD_LAST;
                    inst_d[INST_LOAD] = 1'b1;
                end
            end
            S_LOAD: begin
                if (tc) begin
                    state_d  = S_GAP;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(GAP - 1);
                end else begin
                    cnt_dec           = 1'b1;
                    k_n               = LOAD_LAST - cnt + CNT_W'(1);
                    inst_d[INST_LOAD] = (k_n <= COL_N + CNT_W'(1));
                    if (k_n >= CNT_W'(1) && k_n <= COL_N) begin
                        inst_d[INST_KMEM_RD]              = 1'b1;
                        inst_d[INST_QKMEM_ADD +: ADDR_W] = ADDR_W'(k_n - CNT_W'(1));
                    end
                end
            end
            S_GAP: begin
                if (tc) begin
                    state_d              = S_EXEC;
                    cnt_load             = 1'b1;
                    cnt_val              = CNT_W'(rows - 1);
                    inst_d[INST_EXECUTE] = 1'b1;
                    inst_d[INST_QMEM_RD] = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_EXEC: begin
                if (tc) begin
                    state_d  = S_DRAIN;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(DRAIN - 1);
                end else begin
                    cnt_dec                          = 1'b1;
                    inst_d[INST_EXECUTE]             = 1'b1;
                    inst_d[INST_QMEM_RD]             = 1'b1;
                    inst_d[INST_QKMEM_ADD +: ADDR_W] = qk_add + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                if (tc) begin
                    state_d               = S_MOVE;
                    cnt_load              = 1'b1;
                    cnt_val               = CNT_W'(rows - 1);
                    inst_d[INST_OFIFO_RD] = 1'b1;
                    inst_d[INST_PMEM_WR]  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_MOVE: begin
                if (tc) begin
                    state_d              = S_SFP_RD;
                    inst_d[INST_PMEM_RD] = 1'b1;
                end else begin
                    cnt_dec                         = 1'b1;
                    inst_d[INST_OFIFO_RD]           = 1'b1;
                    inst_d[INST_PMEM_WR]            = 1'b1;
                    inst_d[INST_PMEM_ADD +: ADDR_W] = pm_add + ADDR_W'(1);
                end
            end
            S_SFP_RD: begin
                state_d                         = S_SFP_ACC;
                inst_d[INST_PMEM_RD]            = 1'b1;
                inst_d[INST_SFP_ACC]            = 1'b1;
                inst_d[INST_PMEM_ADD +: ADDR_W] = pm_add;
            end
            S_SFP_ACC: begin
                state_d                         = S_SFP_DIV;
                cnt_load                        = 1'b1;
                cnt_val                         = CNT_W'(DIV_LAT - 1);
                inst_d[INST_PMEM_RD]            = 1'b1;
                inst_d[INST_SFP_DIV]            = 1'b1;
                inst_d[INST_PMEM_ADD +: ADDR_W] = pm_add;
            end
            S_SFP_DIV: begin
                inst_d[INST_SFP_DIV]            = 1'b1;
                inst_d[INST_PMEM_ADD +: ADDR_W] = pm_add;
                if (tc) begin
                    state_d              = S_SFP_WB;
                    inst_d[INST_PMEM_WR] = 1'b1;
                end else begin
                    cnt_dec              = 1'b1;
                    inst_d[INST_PMEM_RD] = 1'b1;
                end
            end
            S_SFP_WB: begin
                if (pm_add == ROW_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d                         = S_SFP_RD;
                    inst_d[INST_PMEM_RD]            = 1'b1;
                    inst_d[INST_PMEM_ADD +: ADDR_W] = pm_add + ADDR_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            inst_q     <= '0;
            mem_in_q   <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            inst_q     <= inst_d;
            mem_in_q   <= mem_in_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign inst     = inst_q;
    assign mem_in   = mem_in_q;
    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;

`ifdef QK_SEQ_PERF_EN
    logic [15:0] perf_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            perf_q <= '0;
        end else if (busy_q && perf_q != '1) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_qk_inst_sequencer.sv
// Self-checking bench for qk_inst_sequencer: handshake-level write model,
// spec-derived inst schedule for the timed phases, and a phase-timing table.
module tb_qk_inst_sequencer;

    localparam int unsigned BW      = 8;
    localparam int unsigned PR      = 8;
    localparam int unsigned COL     = 8;
    localparam int unsigned ROWS    = 8;
    localparam int unsigned GAP     = 10;
    localparam int unsigned DRAIN   = 10;
    localparam int unsigned DIV_LAT = 2;
    localparam int unsigned DW      = PR * BW;

    logic          clk      = 1'b0;
    logic          reset_n  = 1'b1;
    logic          start    = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data  = '0;
    logic [DW-1:0] mem_in;
    logic [18:0]   inst;
    logic          busy;
    logic          done;
`ifdef QK_SEQ_PERF_EN
    logic [15:0]   perf_cycles;
`endif

    int unsigned   total = 0;
    int unsigned   bad   = 0;
    int unsigned   nbusy;
    logic [19:0]   post_q[$];
    logic [19:0]   trace[$];

    typedef struct {
        int unsigned bitn;
        int unsigned first;
        int unsigned cnt;
    } tim_t;
    tim_t tbl[10];

    qk_inst_sequencer #(
        .bw      (BW),
        .pr      (PR),
        .col     (COL),
        .rows    (ROWS),
        .GAP     (GAP),
        .DRAIN   (DRAIN),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .mem_in   (mem_in),
        .inst     (inst),
        .busy     (busy),
        .done     (done)
`ifdef QK_SEQ_PERF_EN
       ,.perf_cycles (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected {done, inst} for every cycle from the first LOAD cycle to DONE.
    task automatic build_post();
        logic [19:0] w;
        post_q.delete();
        for (int unsigned k = 0; k <= COL + 2; k++) begin
            w = '0;
            if (k <= COL + 1) w[6] = 1'b1;
            if (k >= 1 && k <= COL) begin
                w[3]     = 1'b1;
                w[15:12] = 4'(k - 1);
            end
            post_q.push_back(w);
        end
        repeat (GAP) post_q.push_back(20'h0);
        for (int unsigned r = 0; r < ROWS; r++) begin
            w = '0; w[7] = 1'b1; w[5] = 1'b1; w[15:12] = 4'(r);
            post_q.push_back(w);
        end
        repeat (DRAIN) post_q.push_back(20'h0);
        for (int unsigned r = 0; r < ROWS; r++) begin
            w = '0; w[16] = 1'b1; w[0] = 1'b1; w[11:8] = 4'(r);
            post_q.push_back(w);
        end
        for (int unsigned r = 0; r < ROWS; r++) begin
            w = '0; w[11:8] = 4'(r); w[1] = 1'b1;
            post_q.push_back(w);
            w[17] = 1'b1;
            post_q.push_back(w);
            for (int unsigned j = 0; j < DIV_LAT; j++) begin
                w = '0; w[11:8] = 4'(r); w[1] = 1'b1; w[18] = 1'b1;
                post_q.push_back(w);
            end
            w = '0; w[11:8] = 4'(r); w[0] = 1'b1; w[18] = 1'b1;
            post_q.push_back(w);
        end
        w = '0; w[19] = 1'b1;
        post_q.push_back(w);
    endtask

    // mode 0: valid held high, 1: valid every other cycle, 2: random valid.
    task automatic run(input int mode, input bit capture);
        bit            exp_rdy, sel, fin, v, alt;
        int unsigned   cnt, guard;
        logic [DW-1:0] d;
        logic [18:0]   e_inst;

        nbusy    = 0;
        start    = 1'b1;
        in_valid = 1'b0;
        tick();
        start = 1'b0;
        check("wr_entry", {done, busy, in_ready, inst}, {1'b0, 1'b1, 1'b1, 19'h0});
        nbusy++;

        exp_rdy = 1'b1; sel = 1'b0; cnt = 0; fin = 1'b0; guard = 0; alt = 1'b1;
        while (!fin && guard < 400) begin
            case (mode)
                0:       v = 1'b1;
                1:       begin v = alt; alt = !alt; end
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            d        = {$urandom, $urandom};
            in_valid = v;
            in_data  = d;
            start    = 1'($urandom_range(0, 1));
            tick();
            guard++;
            e_inst = '0;
            if (exp_rdy && v) begin
                e_inst[sel ? 2 : 4] = 1'b1;
                e_inst[15:12]       = cnt[3:0];
                check(sel ? "kwr_data" : "qwr_data", mem_in, d);
                cnt++;
                if (cnt == (sel ? COL : ROWS)) exp_rdy = 1'b0;
            end else if (!exp_rdy) begin
                if (!sel) begin
                    sel = 1'b1; cnt = 0; exp_rdy = 1'b1;
                end else begin
                    fin = 1'b1;
                end
            end
            if (!fin) begin
                check(sel ? "kwr" : "qwr", {done, busy, in_ready, inst}, {1'b0, 1'b1, exp_rdy, e_inst});
                nbusy++;
            end
        end
        if (!fin) begin
            check("wr_timeout", 64'(fin), 64'd1);
            start = 1'b0; in_valid = 1'b0;
            return;
        end

        for (int i = 0; i < post_q.size(); i++) begin
            if (capture) trace.push_back({done, inst});
            check($sformatf("post%0d", i), {done, busy, in_ready, inst},
                  {post_q[i][19], 1'b1, 1'b0, post_q[i][18:0]});
            nbusy++;
            in_valid = 1'($urandom_range(0, 1));
            in_data  = {$urandom, $urandom};
            start    = 1'($urandom_range(0, 1));
            tick();
        end
        start    = 1'b0;
        in_valid = 1'b0;
        check("idle_after", {done, busy, in_ready, inst}, 64'h0);
`ifdef QK_SEQ_PERF_EN
        check("perf", perf_cycles, nbusy[15:0]);
`endif
        tick();
        check("idle_hold", {done, busy, in_ready}, 64'h0);
`ifdef QK_SEQ_PERF_EN
        check("perf_hold", perf_cycles, nbusy[15:0]);
`endif
    endtask

    initial begin
        int unsigned guard;
        int unsigned first, cnt;

        // Bit 19 stands for done; offsets count from the first LOAD cycle.
        tbl[0] = '{bitn: 6,  first: 0,  cnt: 10};
        tbl[1] = '{bitn: 3,  first: 1,  cnt: 8};
        tbl[2] = '{bitn: 7,  first: 21, cnt: 8};
        tbl[3] = '{bitn: 5,  first: 21, cnt: 8};
        tbl[4] = '{bitn: 16, first: 39, cnt: 8};
        tbl[5] = '{bitn: 0,  first: 39, cnt: 16};
        tbl[6] = '{bitn: 1,  first: 47, cnt: 32};
        tbl[7] = '{bitn: 17, first: 48, cnt: 8};
        tbl[8] = '{bitn: 18, first: 49, cnt: 24};
        tbl[9] = '{bitn: 19, first: 87, cnt: 1};
        build_post();

        #1 reset_n = 1'b0;
        #10;
        check("rst_ctl", {done, busy, in_ready, inst}, 64'h0);
        check("rst_mem", mem_in, 64'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        check("idle_init", {done, busy, in_ready, inst}, 64'h0);

        run(0, 1'b1);
        check("trace_len", trace.size(), 64'd88);
        for (int t = 0; t < 10; t++) begin
            first = 9999;
            cnt   = 0;
            for (int i = 0; i < trace.size(); i++) begin
                if (trace[i][tbl[t].bitn]) begin
                    if (cnt == 0) first = i;
                    cnt++;
                end
            end
            check($sformatf("tim_b%0d_first", tbl[t].bitn), first, tbl[t].first);
            check($sformatf("tim_b%0d_count", tbl[t].bitn), cnt, tbl[t].cnt);
        end

        run(1, 1'b0);
        repeat (3) run(2, 1'b0);

        start    = 1'b1;
        in_valid = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (!inst[7] && guard < 300) begin
            in_data = {$urandom, $urandom};
            tick();
            guard++;
        end
        check("exec_reached", 64'(inst[7]), 64'd1);
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid", {done, busy, in_ready, inst}, 64'h0);
        in_valid = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        check("rst_idle", {done, busy, in_ready, inst}, 64'h0);
        check("rst_idle_mem", mem_in, 64'h0);
`ifdef QK_SEQ_PERF_EN
        check("rst_perf", perf_cycles, 64'h0);
`endif
        run(0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
